// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small circular FIFO.
//   clk_core  core clock
//   reset     asynchronous, active-high reset
//   rx        raw serial input (asynchronous, idle high)
//   rd_data   byte at FIFO head, valid while rd_valid=1
//   rd_valid  FIFO not empty
//   rd_pop    single-cycle strobe removing the head byte
//   overrun   sticky: byte completed while FIFO full (dropped)
//   frame_err sticky: stop bit sampled low (dropped)
//   err_clr   clears both sticky flags (a same-cycle set wins)
//   cts_n     1 = host must stop sending (registered from level)
//   level     current FIFO occupancy 0..2**FIFO_AW
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 416,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned CTS_MARGIN   = 4
) (
  input  logic             clk_core,
  input  logic             reset,
  input  logic             rx,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_pop,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr,
  output logic             cts_n,
  output logic [FIFO_AW:0] level
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0]   FULL_LVL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CTS_LVL     = (FIFO_AW + 1)'(DEPTH - CTS_MARGIN);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t       state;
  logic         rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic         strobe;
  logic [2:0]   bit_idx;
  logic [7:0]   rx_byte;
  logic         push_q;

  // Two-flop synchroniser; idle-high reset value avoids a spurious start.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_comb begin
    strobe = (cnt == '0);
  end

  // Receiver FSM. push_q is a one-cycle request; rx_byte stays stable
  // until the next DATA state, so the FIFO can write it on the next edge.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr) frame_err <= 1'b0;
      if (state == S_START || state == S_DATA || state == S_STOP)
        cnt <= strobe ? BIT_RELOAD : cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_RELOAD;
            state <= S_START;
          end
        end
        S_START: begin
          if (strobe) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
        end
        S_DATA: begin
          if (strobe) begin
            rx_byte[bit_idx] <= rx_s;
            bit_idx          <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (strobe) begin
            if (rx_s) begin
              push_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [FIFO_AW:0]   level_nx;
  logic               do_pop, do_push;
  logic [7:0]         head_nx;

  always_comb begin
    do_pop    = rd_pop && (level != '0);
    do_push   = push_q && ((level != FULL_LVL) || do_pop);
    rd_ptr_nx = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nx  = level;
    if (do_push && !do_pop)      level_nx = level + 1'b1;
    else if (!do_push && do_pop) level_nx = level - 1'b1;
    // Bypass when the new head is the slot being written this cycle.
    head_nx = (do_push && (wr_ptr == rd_ptr_nx)) ? rx_byte : mem[rd_ptr_nx];
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overrun  <= 1'b0;
      cts_n    <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= rx_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_ptr_nx;
      level    <= level_nx;
      rd_valid <= (level_nx != '0);
      if (level_nx != '0) rd_data <= head_nx;
      cts_n <= (level >= CTS_LVL);
      if (push_q && !do_push) overrun <= 1'b1;
      else if (err_clr)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized checks of uart_rx_fifo at
// 16 clocks per bit, depth 4, cts threshold 3, against a queue model.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int AW  = 2;
  localparam int DEP = 4;
  localparam int CTS_TH = 3;

  logic          clk_core = 1'b0;
  logic          reset;
  logic          rx;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_pop;
  logic          overrun;
  logic          frame_err;
  logic          err_clr;
  logic          cts_n;
  logic [AW:0]   level;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .CTS_MARGIN(1)) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .rx       (rx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_pop   (rd_pop),
    .overrun  (overrun),
    .frame_err(frame_err),
    .err_clr  (err_clr),
    .cts_n    (cts_n),
    .level    (level)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, rd_valid, q.size() != 0);
    check({tag, "_level"}, level, q.size());
    check({tag, "_cts"}, cts_n, q.size() >= CTS_TH);
    check({tag, "_ovr"}, overrun, m_ovr);
    check({tag, "_ferr"}, frame_err, m_ferr);
    if (q.size() != 0) check({tag, "_data"}, rd_data, q[0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  // One 8N1 frame, one bit per CPB clocks, starting at the current negedge.
  // rd_pop is driven high during clock index pop_at (-1 = never).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      rx     = f[k / CPB];
      rd_pop = (k == pop_at);
      @(negedge clk_core);
    end
    rx     = 1'b1;
    rd_pop = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEP) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_pre_valid"}, rd_valid, 1'b1);
    if (q.size() != 0) check({tag, "_pre_data"}, rd_data, q[0]);
    rd_pop = 1'b1;
    @(negedge clk_core);
    rd_pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk_core);
    check_all(tag);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk_core);
    err_clr = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] b5;
    reset = 1'b1; rx = 1'b1; rd_pop = 1'b0; err_clr = 1'b0;
    idle(3);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_cts", cts_n, 1'b1);
    reset = 1'b0;
    check("cts_before_edge", cts_n, 1'b1);
    @(negedge clk_core);
    check("cts_after_edge", cts_n, 1'b0);
    idle(5);

    // Two back-to-back frames, read in order, then pop on empty.
    send_frame(8'h55, 1'b1, -1); model_push(8'h55);
    send_frame(8'hA3, 1'b1, -1); model_push(8'hA3);
    idle(2);
    check_all("t1_two");
    pop_check("t1_pop1");
    pop_check("t1_pop2");
    rd_pop = 1'b1; @(negedge clk_core); rd_pop = 1'b0; idle(1);
    check_all("t1_pop_empty");

    // Short low glitch: false start, then a real frame must still work.
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(40);
    check_all("t2_glitch");
    send_frame(8'h96, 1'b1, -1); model_push(8'h96);
    idle(2);
    check_all("t2_after");
    pop_check("t2_pop");

    // Stop bit low then line held low: one frame error, no new frame.
    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b0;
    idle(40);
    m_ferr = 1'b1;
    check_all("t3_break");
    clear_errs();
    idle(1);
    check_all("t3_clr_low");
    idle(40);
    rx = 1'b1;
    idle(200);
    check_all("t3_released");
    send_frame(8'hC3, 1'b1, -1); model_push(8'hC3);
    idle(2);
    check_all("t3_next");
    pop_check("t3_pop");

    // Five bytes, no pops: cts after three, overrun on the fifth.
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, -1); model_push(b);
      idle(2);
      check_all($sformatf("t4_byte%0d", i + 1));
    end
    for (int i = 0; i < 4; i++) pop_check($sformatf("t4_read%0d", i));
    clear_errs();
    idle(1);
    check_all("t4_clr");

    // Full FIFO, pop on the very edge the fifth byte is written.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, -1); model_push(b);
    end
    idle(2);
    check_all("t5_full");
    b5 = 8'($urandom);
    // rx falls at clock index 0; rx_s low after 2 edges, IDLE sees it on
    // the 3rd, stop sample 152 edges later, FIFO write on the next edge:
    // the 156th edge, which samples rd_pop driven at index 155.
    send_frame(b5, 1'b1, 155);
    void'(q.pop_front());
    q.push_back(b5);
    idle(2);
    check_all("t5_pushpop");
    for (int i = 0; i < 4; i++) pop_check($sformatf("t5_read%0d", i));

    // Randomized traffic with random pops.
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, -1); model_push(b);
      idle(2);
      check_all($sformatf("rnd_rx%0d", i));
      if ($urandom_range(0, 2) != 0 && q.size() != 0) pop_check($sformatf("rnd_pop%0d", i));
    end
    while (q.size() != 0) pop_check("rnd_drain");
    clear_errs();
    idle(1);
    check_all("rnd_clr");

    // Reset in the middle of data bit 4 with a byte already queued.
    send_frame(8'h5A, 1'b1, -1); model_push(8'h5A);
    idle(2);
    check_all("t6_pre");
    begin
      logic [9:0] f;
      f = {1'b1, 8'hE7, 1'b0};
      for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
        rx = f[k / CPB];
        @(negedge clk_core);
      end
    end
    reset = 1'b1;
    #1;
    q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    check("t6_rst_valid", rd_valid, 1'b0);
    check("t6_rst_data", rd_data, 8'h00);
    check("t6_rst_level", level, 0);
    check("t6_rst_ovr", overrun, 1'b0);
    check("t6_rst_ferr", frame_err, 1'b0);
    check("t6_rst_cts", cts_n, 1'b1);
    @(negedge clk_core);
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk_core);
    check("t6_cts_fall", cts_n, 1'b0);
    idle(200);
    check_all("t6_idle");
    send_frame(8'h81, 1'b1, -1); model_push(8'h81);
    idle(2);
    check_all("t6_next");
    pop_check("t6_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
